// File: rtl/datapath_pkg.sv
// Shared definitions for the register-file/ALU datapath: widths, opcode
// nibbles, flag bit positions and the opcode decoder used by both the ALU
// and the immediate-extension logic.
package datapath_pkg;

    localparam int DATA_W   = 16;
    localparam int IMM_W    = 8;
    localparam int NUM_REGS = 16;
    localparam int FLAG_W   = 5;

    // Opcode nibbles: register ops carry these in op_ext with op_hi=0000,
    // immediate ops carry them in op_hi.
    localparam logic [3:0] OP_HI_REG = 4'b0000;
    localparam logic [3:0] OP_ADD    = 4'b0101;
    localparam logic [3:0] OP_SUB    = 4'b1001;
    localparam logic [3:0] OP_CMP    = 4'b1011;
    localparam logic [3:0] OP_AND    = 4'b0001;
    localparam logic [3:0] OP_OR     = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_MOV    = 4'b1101;

    // Bit positions inside the {C, L, F, Z, N} flags vector.
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_CMP,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_MOV,
        ALU_BAD
    } alu_kind_e;

    // op_hi wins: a non-zero high nibble names an immediate op and op_ext is
    // ignored, so an X in op_ext cannot disturb an immediate instruction.
    function automatic alu_kind_e decode_op(input logic [7:0] op);
        logic [3:0] code;
        code = (op[7:4] != OP_HI_REG) ? op[7:4] : op[3:0];
        case (code)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_CMP:  return ALU_CMP;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_MOV:  return ALU_MOV;
            default: return ALU_BAD;
        endcase
    endfunction

    // Arithmetic and compare take a sign-extended immediate; logical ops and
    // MOV take it zero-extended.
    function automatic logic imm_is_signed(input alu_kind_e kind);
        return kind inside {ALU_ADD, ALU_SUB, ALU_CMP};
    endfunction

endpackage

// File: rtl/regfile_alu_datapath_alu16.sv
// Purely combinational 16-bit ALU. Besides the result it reports which flags
// the operation is allowed to update and whether the result may be written
// back, so the sequential logic in the top stays a plain enable/mask.
module alu16
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_kind_e         kind,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flag_val,
    output logic [FLAG_W-1:0] flag_upd,
    output logic              wr_allow
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            add_ovf;
    logic            sub_ovf;

    // Extra top bit carries the carry-out of the add and the borrow of the
    // subtract (borrow is set exactly when a < b unsigned).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
    assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

    // Result, flag values and update masks per operation.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        result   = '0;
        flag_val = '0;
        flag_upd = '0;
        wr_allow = 1'b0;
        case (kind)
            ALU_ADD: begin
                result           = sum[DATA_W-1:0];
                wr_allow         = 1'b1;
                flag_val[FLAG_C] = sum[DATA_W];
                flag_val[FLAG_F] = add_ovf;
                flag_upd[FLAG_C] = 1'b1;
                flag_upd[FLAG_F] = 1'b1;
            end
            ALU_SUB: begin
                result           = diff[DATA_W-1:0];
                wr_allow         = 1'b1;
                flag_val[FLAG_C] = diff[DATA_W];
                flag_val[FLAG_F] = sub_ovf;
                flag_upd[FLAG_C] = 1'b1;
                flag_upd[FLAG_F] = 1'b1;
            end
            ALU_CMP: begin
                result           = diff[DATA_W-1:0];
                flag_val[FLAG_Z] = (a == b);
                flag_val[FLAG_L] = diff[DATA_W];
                flag_val[FLAG_N] = ($signed(a) < $signed(b));
                flag_upd[FLAG_Z] = 1'b1;
                flag_upd[FLAG_L] = 1'b1;
                flag_upd[FLAG_N] = 1'b1;
            end
            ALU_AND: begin
                result   = a & b;
                wr_allow = 1'b1;
            end
            ALU_OR: begin
                result   = a | b;
                wr_allow = 1'b1;
            end
            ALU_XOR: begin
                result   = a ^ b;
                wr_allow = 1'b1;
            end
            ALU_MOV: begin
                result   = b;
                wr_allow = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_alu_datapath.sv
// Execution datapath consuming the sequencer's control word: 16x16 register
// file with multi-hot write enables, operand muxes, ALU and flags register.
module regfile_alu_datapath #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       R_en,
    input  logic [3:0]        R_src,
    input  logic [3:0]        R_dest,
    input  logic              R_or_I,
    input  logic [7:0]        ALU_op,
    input  logic              Flag_en,
    input  logic [IMM_W-1:0]  imm,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] alu_out,
    output logic [4:0]        flags
);

    import datapath_pkg::*;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [FLAG_W-1:0] flags_q;

    alu_kind_e         kind;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] alu_result;
    logic [FLAG_W-1:0] flag_val;
    logic [FLAG_W-1:0] flag_upd;
    logic              alu_wr_allow;

    assign kind    = decode_op(ALU_op);
    assign imm_ext = imm_is_signed(kind) ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                                         : {{(DATA_W-IMM_W){1'b0}}, imm};

    // Reads are combinational off the current array, so a register used as
    // both source and destination sees its pre-edge value.
    assign opnd_a = regs[R_src];
    assign opnd_b = R_or_I ? imm_ext : regs[R_dest];

    alu16 u_alu (
        .a        (opnd_a),
        .b        (opnd_b),
        .kind     (kind),
        .result   (alu_result),
        .flag_val (flag_val),
        .flag_upd (flag_upd),
        .wr_allow (alu_wr_allow)
    );

    assign alu_out  = alu_result;
    assign dbg_data = regs[dbg_sel];
    assign flags    = flags_q;

    // Register file: every enabled register takes the ALU result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this array is flops, not a RAM macro, and must read zero straight out of reset, so it is reset explicitly.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: non-blocking so all registers sample the same pre-edge ALU result.
                if (R_en[i] & alu_wr_allow) begin
                    regs[i] <= alu_result;
                end
            end
        end
    end

    // Flags register: only the flags the current op owns are loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else begin
            for (int b = 0; b < FLAG_W; b++) begin
                if (Flag_en & flag_upd[b]) begin
                    flags_q[b] <= flag_val[b];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Self-checking bench for regfile_alu_datapath: an integer-arithmetic model
// tracks registers and flags; a negedge process compares every cycle, and
// directed sequences pin the model with hand-computed values.
module tb_regfile_alu_datapath;

    localparam int K_ADD = 0, K_SUB = 1, K_CMP = 2, K_AND = 3,
                   K_OR  = 4, K_XOR = 5, K_MOV = 6, K_BAD = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] R_en = '0;
    logic [3:0]  R_src = '0;
    logic [3:0]  R_dest = '0;
    logic        R_or_I = 1'b0;
    logic [7:0]  ALU_op = 8'h05;
    logic        Flag_en = 1'b0;
    logic [7:0]  imm = '0;
    logic [3:0]  dbg_sel = '0;
    logic [15:0] dbg_data;
    logic [15:0] alu_out;
    logic [4:0]  flags;

    int   checks   = 0;
    int   failures = 0;
    bit   check_en = 1'b0;
    bit   xmode    = 1'b0;

    int         m_regs [16];
    logic [4:0] m_flags = '0;

    regfile_alu_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .R_en     (R_en),
        .R_src    (R_src),
        .R_dest   (R_dest),
        .R_or_I   (R_or_I),
        .ALU_op   (ALU_op),
        .Flag_en  (Flag_en),
        .imm      (imm),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .alu_out  (alu_out),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int kind_of(input logic [7:0] op);
        int code;
        code = (op[7:4] != 4'h0) ? int'(op[7:4]) : int'(op[3:0]);
        case (code)
            5:       return K_ADD;
            9:       return K_SUB;
            11:      return K_CMP;
            1:       return K_AND;
            2:       return K_OR;
            3:       return K_XOR;
            13:      return K_MOV;
            default: return K_BAD;
        endcase
    endfunction

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic int operand_b(input int k, input logic roi, input logic [7:0] im, input int rd_val);
        int v;
        if (!roi) return rd_val;
        v = int'(im);
        if ((k == K_ADD || k == K_SUB || k == K_CMP) && v >= 128) v = v + 65280;
        return v;
    endfunction

    function automatic void model_eval(input int k, input int a, input int b,
                                       input logic [4:0] of, output int res,
                                       output bit wr, output logic [4:0] nf);
        int t, ts;
        nf  = of;
        wr  = 1'b1;
        res = 0;
        case (k)
            K_ADD: begin
                t = a + b; res = t % 65536;
                ts = to_signed16(a) + to_signed16(b);
                nf[4] = (t > 65535);
                nf[2] = (ts > 32767) || (ts < -32768);
            end
            K_SUB, K_CMP: begin
                t = a - b; res = (t + 65536) % 65536;
                ts = to_signed16(a) - to_signed16(b);
                if (k == K_SUB) begin
                    nf[4] = (a < b);
                    nf[2] = (ts > 32767) || (ts < -32768);
                end else begin
                    wr = 1'b0;
                    nf[1] = (a == b);
                    nf[3] = (a < b);
                    nf[0] = (to_signed16(a) < to_signed16(b));
                end
            end
            K_AND: res = a & b;
            K_OR:  res = a | b;
            K_XOR: res = a ^ b;
            K_MOV: res = b;
            default: wr = 1'b0;
        endcase
    endfunction

    // Model state update on each active edge.
    always @(posedge clk) begin
        if (rst === 1'b1 && (R_en != 16'h0 || Flag_en)) begin
            int k, a, b, res;
            bit wr;
            logic [4:0] nf;
            k = kind_of(ALU_op);
            a = m_regs[R_src];
            b = operand_b(k, R_or_I, imm, m_regs[R_dest]);
            model_eval(k, a, b, m_flags, res, wr, nf);
            if (wr) begin
                for (int i = 0; i < 16; i++) if (R_en[i]) m_regs[i] = res;
            end
            if (Flag_en) m_flags = nf;
        end
    end

    always @(negedge rst) begin
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_flags = '0;
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            int k, a, b, res;
            bit wr;
            logic [4:0] nf;
            if (!xmode) begin
                k = kind_of(ALU_op);
                a = m_regs[R_src];
                b = operand_b(k, R_or_I, imm, m_regs[R_dest]);
                model_eval(k, a, b, m_flags, res, wr, nf);
                check("alu_out", 32'(alu_out), 32'(res));
            end
            check("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_sel]));
            check("flags", 32'(flags), 32'(m_flags));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        R_en = '0; Flag_en = 1'b0; ALU_op = 8'h05; R_or_I = 1'b0; imm = '0; xmode = 1'b0;
    endtask

    task automatic drive(input logic [15:0] en, input logic [3:0] src, input logic [3:0] dst,
                         input logic roi, input logic [7:0] op, input logic fen,
                         input logic [7:0] im);
        @(posedge clk); #1;
        R_en = en; R_src = src; R_dest = dst; R_or_I = roi;
        ALU_op = op; Flag_en = fen; imm = im; xmode = 1'b0;
    endtask

    task automatic expect_dbg(input string name, input logic [3:0] sel, input logic [15:0] val);
        @(posedge clk); #1;
        set_idle();
        dbg_sel = sel;
        @(negedge clk); #1;
        check(name, 32'(dbg_data), 32'(val));
    endtask

    task automatic expect_flags(input string name, input logic [4:0] val);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk); #1;
        check(name, 32'(flags), 32'(val));
    endtask

    // Drops reset between edges with a write still pending on the inputs.
    task automatic async_reset(input bit pin);
        @(posedge clk); #2;
        dbg_sel = 4'd5;
        rst = 1'b0;
        #1;
        if (pin) begin
            check("rst_dbg", 32'(dbg_data), 32'h0);
            check("rst_flags", 32'(flags), 32'h0);
        end
        set_idle();
        #1 rst = 1'b1;
    endtask

    int fib_exp [15] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
    int codes [7]    = '{5, 9, 11, 1, 2, 3, 13};

    initial begin
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_dbg_r0", 32'(dbg_data), 32'h0);
        check("reset_flags", 32'(flags), 32'h0);
        check("reset_alu_add", 32'(alu_out), 32'h0);
        #1 rst = 1'b1;
        check_en = 1'b1;

        // Fibonacci
        drive(16'h0003, 4'd0, 4'd0, 1'b1, 8'h50, 1'b0, 8'h01);
        for (int n = 2; n <= 14; n++)
            drive(16'(1 << n), 4'(n - 2), 4'(n - 1), 1'b0, 8'h05, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++)
            expect_dbg($sformatf("fib_r%0d", i), 4'(i), 16'(fib_exp[i]));
        expect_dbg("fib_r15", 4'd15, 16'h0000);

        // Idle cycles with unknown control and no enables
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            R_en = '0; Flag_en = 1'b0; ALU_op = 'x; R_or_I = 'x; imm = 'x; xmode = 1'b1;
        end
        expect_dbg("xidle_r13", 4'd13, 16'd377);
        expect_flags("xidle_flags", 5'b00000);

        // Reset mid-sequence with an all-register write pending
        drive(16'hFFFF, 4'd13, 4'd14, 1'b0, 8'h05, 1'b1, 8'h00);
        async_reset(1'b1);
        expect_dbg("post_rst_r14", 4'd14, 16'h0000);

        // Carry
        drive(16'h0001, 4'd0, 4'd0, 1'b1, 8'h5A, 1'b1, 8'hFF);
        expect_dbg("carry_r0_ffff", 4'd0, 16'hFFFF);
        expect_flags("carry_c0", 5'b00000);
        drive(16'h0001, 4'd0, 4'd0, 1'b0, 8'h05, 1'b1, 8'h00);
        expect_dbg("carry_r0_fffe", 4'd0, 16'hFFFE);
        expect_flags("carry_c1", 5'b10000);

        // Signed overflow
        async_reset(1'b0);
        drive(16'h0002, 4'd0, 4'd0, 1'b1, 8'hD3, 1'b0, 8'h80);
        expect_dbg("movi_zext", 4'd1, 16'h0080);
        for (int i = 0; i < 8; i++)
            drive(16'h0002, 4'd1, 4'd1, 1'b0, 8'h05, 1'b1, 8'h00);
        expect_dbg("ovf_r1", 4'd1, 16'h8000);
        expect_flags("ovf_f1", 5'b00100);

        // Compare
        async_reset(1'b0);
        drive(16'h0004, 4'd0, 4'd0, 1'b1, 8'hD0, 1'b0, 8'h05);
        drive(16'h0008, 4'd0, 4'd0, 1'b1, 8'hD0, 1'b0, 8'h07);
        drive(16'hFFFF, 4'd2, 4'd3, 1'b0, 8'h0B, 1'b1, 8'h00);
        expect_flags("cmp_flags", 5'b01001);
        expect_dbg("cmp_r2", 4'd2, 16'd5);
        expect_dbg("cmp_r3", 4'd3, 16'd7);
        expect_dbg("cmp_r0", 4'd0, 16'd0);

        // Flag_en low: writes happen, flags hold
        drive(16'h0010, 4'd0, 4'd0, 1'b1, 8'h50, 1'b0, 8'hFF);
        drive(16'h0010, 4'd4, 4'd4, 1'b0, 8'h05, 1'b0, 8'h00);
        expect_dbg("fen0_r4", 4'd4, 16'hFFFE);
        expect_flags("fen0_flags", 5'b01001);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [15:0] en;
            logic [7:0]  op;
            int          sel, mode;
            mode = int'($urandom_range(0, 2));
            en   = (mode == 0) ? 16'h0 : (mode == 1) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            sel  = int'($urandom_range(0, 9));
            if (sel < 4)      op = {4'h0, 4'(codes[$urandom_range(0, 6)])};
            else if (sel < 9) op = {4'(codes[$urandom_range(0, 6)]), 4'($urandom_range(0, 15))};
            else              op = ($urandom_range(0, 1) == 1) ? 8'h0E : {4'hF, 4'($urandom_range(0, 15))};
            dbg_sel = 4'($urandom_range(0, 15));
            drive(en, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  op, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        @(posedge clk); #1;
        set_idle();
        @(negedge clk); #1;
        check_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
